// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer in front of the single DMEM + UART TX port (IDLE -> ISSUE -> RESP).
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter logic [31:0] DMEM_BASE    = 32'h1000_0000,
  parameter logic [31:0] DMEM_BYTES   = 32'd131072,
  parameter logic [31:0] UART_TX_ADDR = 32'h2000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_write,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  input  logic [1:0]  m0_req_size,
  input  logic        m0_req_signed,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_write,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  input  logic [1:0]  m1_req_size,
  input  logic        m1_req_signed,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_load_signed,
  output logic [1:0]  mem_load_size,
  output logic [1:0]  mem_store_size,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_gnt0, w_gnt1, w_accept, w_rsp_hs, w_issue, w_resp;
  logic        w_write, w_signed, w_in_range, w_uart, w_misalign, w_err;
  logic [31:0] w_addr, w_wdata;
  logic [1:0]  w_size;
  logic        r_owner, r_write, r_signed, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [1:0]  r_size;

`ifdef DMEM_ARB_RR_EN
  logic r_rr_ptr;

  assign w_gnt0 = m0_req_valid & (~m1_req_valid | ~r_rr_ptr);
  assign w_gnt1 = m1_req_valid & (~m0_req_valid | r_rr_ptr);

  // Pointer always names the port that did not win the last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_rr_ptr <= 1'b0;
    else if (w_accept) r_rr_ptr <= ~w_gnt1;
  end
`else
  assign w_gnt0 = m0_req_valid;
  assign w_gnt1 = m1_req_valid & ~m0_req_valid;
`endif

  assign w_accept     = (r_state == ST_IDLE) & (w_gnt0 | w_gnt1);
  assign m0_req_ready = (r_state == ST_IDLE) & w_gnt0;
  assign m1_req_ready = (r_state == ST_IDLE) & w_gnt1;

  assign w_write  = w_gnt1 ? m1_req_write  : m0_req_write;
  assign w_addr   = w_gnt1 ? m1_req_addr   : m0_req_addr;
  assign w_wdata  = w_gnt1 ? m1_req_wdata  : m0_req_wdata;
  assign w_size   = w_gnt1 ? m1_req_size   : m0_req_size;
  assign w_signed = w_gnt1 ? m1_req_signed : m0_req_signed;

  // The >= guard keeps the subtraction from wrapping into a false hit.
  assign w_in_range = (w_addr >= DMEM_BASE) && ((w_addr - DMEM_BASE) < DMEM_BYTES);
  assign w_uart     = (w_addr == UART_TX_ADDR);
  assign w_misalign = (w_size == 2'b01) ? w_addr[0] : (w_size[1] & (|w_addr[1:0]));
  assign w_err      = w_write ? (~w_uart & (~w_in_range | w_misalign))
                              : (~w_in_range | w_misalign);

  assign w_issue  = (r_state == ST_ISSUE);
  assign w_resp   = (r_state == ST_RESP);
  assign w_rsp_hs = w_resp & (r_owner ? m1_rsp_ready : m0_rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  if (w_rsp_hs) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= 1'b0;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_size   <= '0;
      r_rdata  <= '0;
    end else if (w_accept) begin
      r_owner  <= w_gnt1;
      r_write  <= w_write;
      r_signed <= w_signed;
      r_err    <= w_err;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_size   <= w_size;
      r_rdata  <= '0;
    end else if (w_issue) begin
      r_rdata  <= r_write ? 32'h0 : mem_rdata;
    end
  end

  assign mem_read        = w_issue & ~r_write;
  assign mem_write       = w_issue & r_write;
  assign mem_addr        = w_issue ? r_addr : 32'h0;
  assign mem_wdata       = mem_write ? r_wdata : 32'h0;
  assign mem_load_signed = mem_read & r_signed;
  assign mem_load_size   = mem_read ? r_size : 2'b00;
  assign mem_store_size  = mem_write ? r_size : 2'b00;

  assign m0_rsp_valid = w_resp & ~r_owner;
  assign m1_rsp_valid = w_resp & r_owner;
  assign m0_rsp_rdata = m0_rsp_valid ? r_rdata : 32'h0;
  assign m1_rsp_rdata = m1_rsp_valid ? r_rdata : 32'h0;
  assign m0_rsp_err   = m0_rsp_valid & r_err;
  assign m1_rsp_err   = m1_rsp_valid & r_err;

endmodule
